// File: rtl/gerador_vetores_porta.sv
// Exhaustive truth-table sweep generator and checker for a single logic gate.
// Optional macro VERIF_STOP_ON_FAIL_EN ends the sweep on the first failing vector.
module gerador_vetores_porta #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned FUNC   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dut_y,
    output logic [N_IN-1:0]   vec,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              mismatch
);

    localparam int unsigned ERR_W = N_IN + 1;
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             expected_c;
    logic             miss_c;
    logic [ERR_W-1:0] err_next_c;

    // Reference gate function; unknown FUNC codes fall back to AND
    always_comb begin
        expected_c = &vec;
        case (FUNC)
            32'd1:   expected_c = |vec;
            32'd2:   expected_c = ^vec;
            32'd3:   expected_c = ~(&vec);
            default: expected_c = &vec;
        endcase
        miss_c     = (dut_y != expected_c);
        err_next_c = err_count + ERR_W'(miss_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            mismatch  <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SETTLE;
                        cnt       <= CNT_LOAD;
                        vec       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    mismatch  <= miss_c;
                    err_count <= err_next_c;
`ifdef VERIF_STOP_ON_FAIL_EN
                    if (miss_c) begin
                        // vec is left on the failing pattern for diagnosis
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end else if (vec == VEC_LAST) begin
`else
                    if (vec == VEC_LAST) begin
`endif
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next_c == '0);
                    end else begin
                        state <= ST_SETTLE;
                        cnt   <= CNT_LOAD;
                        vec   <= vec + N_IN'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gerador_vetores_porta.sv
// Directed bench: 2-input AND/OR/stuck-at gate models and a 3-input XOR sweep.
module tb_gerador_vetores_porta;

    logic       clk = 1'b0;
    logic       rst;
    logic       start2, start3;
    logic [1:0] mode;
    logic       y2, y3;
    logic [1:0] vec2;
    logic [2:0] vec3;
    logic       busy2, done2, pass2, mm2;
    logic       busy3, done3, pass3, mm3;
    logic [2:0] err2;
    logic [3:0] err3;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    // mode 0 = correct AND, 1 = OR in place of AND, 2 = output stuck at 1
    assign y2 = (mode == 2'd0) ? (&vec2) : (mode == 2'd1) ? (|vec2) : 1'b1;
    assign y3 = ^vec3;

    gerador_vetores_porta #(.N_IN(2), .SETTLE(2), .FUNC(0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .dut_y(y2), .vec(vec2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .mismatch(mm2)
    );

    gerador_vetores_porta #(.N_IN(3), .SETTLE(2), .FUNC(2)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .dut_y(y3), .vec(vec3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .mismatch(mm3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero2(input string tag);
        check({tag, "_vec"},  32'(vec2),  32'd0);
        check({tag, "_busy"}, 32'(busy2), 32'd0);
        check({tag, "_done"}, 32'(done2), 32'd0);
        check({tag, "_pass"}, 32'(pass2), 32'd0);
        check({tag, "_err"},  32'(err2),  32'd0);
        check({tag, "_mm"},   32'(mm2),   32'd0);
    endtask

    // Run one 2-input sweep of fixed length; mismatch pulses collected by cycle index
    task automatic sweep2(input string tag, input int len, input logic [15:0] exp_mm,
                          input logic [2:0] exp_err, input logic exp_pass,
                          input logic [1:0] exp_vec_end);
        logic [15:0] mm;
        mm = '0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check({tag, "_vec0"},  32'(vec2),  32'd0);
        check({tag, "_busy0"}, 32'(busy2), 32'd1);
        check({tag, "_done0"}, 32'(done2), 32'd0);
        for (int i = 1; i <= len; i++) begin
            tick();
            mm[i] = mm2;
            if (i < len) begin
                check($sformatf("%s_vec_c%0d", tag, i), 32'(vec2), 32'(i / 3));
                check($sformatf("%s_done_c%0d", tag, i), 32'(done2), 32'd0);
            end
        end
        check({tag, "_done"},    32'(done2), 32'd1);
        check({tag, "_busy"},    32'(busy2), 32'd0);
        check({tag, "_pass"},    32'(pass2), 32'(exp_pass));
        check({tag, "_err"},     32'(err2),  32'(exp_err));
        check({tag, "_mm_mask"}, 32'(mm),    32'(exp_mm));
        check({tag, "_vec_end"}, 32'(vec2),  32'(exp_vec_end));
    endtask

    initial begin
        logic [15:0] mm;
        rst    = 1'b1;
        start2 = 1'b0;
        start3 = 1'b0;
        mode   = 2'd0;
        tick();
        tick();
        rst = 1'b0;
        check_all_zero2("por");

        // Reset in the middle of a sweep at vec = 10
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_vec", 32'(vec2), 32'd2);
        rst = 1'b1;
        tick();
        check_all_zero2("rst_edge1");
        tick();
        rst = 1'b0;
        check_all_zero2("rst_edge2");
        tick();
        check("rst_idle_busy", 32'(busy2), 32'd0);

        // Correct AND gate
        mode = 2'd0;
        sweep2("and_ok", 12, 16'h0000, 3'd0, 1'b1, 2'b11);
        tick();
        check("and_ok_done_sticky", 32'(done2), 32'd1);
        check("and_ok_pass_sticky", 32'(pass2), 32'd1);

        // OR model in place of AND: mismatches on 01 and 10
        mode = 2'd1;
`ifdef VERIF_STOP_ON_FAIL_EN
        sweep2("or_gate", 6, 16'h0040, 3'd1, 1'b0, 2'b01);
`else
        sweep2("or_gate", 12, 16'h0240, 3'd2, 1'b0, 2'b11);
`endif

        // Output stuck at 1: mismatches on 00, 01 and 10
        mode = 2'd2;
`ifdef VERIF_STOP_ON_FAIL_EN
        sweep2("stuck1", 3, 16'h0008, 3'd1, 1'b0, 2'b00);
`else
        sweep2("stuck1", 12, 16'h0248, 3'd3, 1'b0, 2'b11);
`endif

        // start held high across a full sweep must not restart it
        mode   = 2'd0;
        start2 = 1'b1;
        tick();
        check("hold_vec0", 32'(vec2), 32'd0);
        for (int i = 1; i < 12; i++) begin
            tick();
            check($sformatf("hold_vec_c%0d", i), 32'(vec2), 32'(i / 3));
        end
        tick();
        check("hold_done", 32'(done2), 32'd1);
        check("hold_pass", 32'(pass2), 32'd1);
        tick();
        check("hold_restart_done", 32'(done2), 32'd0);
        check("hold_restart_pass", 32'(pass2), 32'd0);
        check("hold_restart_vec",  32'(vec2),  32'd0);
        check("hold_restart_busy", 32'(busy2), 32'd1);
        start2 = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("hold_second_done", 32'(done2), 32'd1);

        // 3-input XOR sweep: 8 vectors x 3 cycles
        mm = '0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("xor3_vec0", 32'(vec3), 32'd0);
        for (int i = 1; i <= 24; i++) begin
            tick();
            mm[i % 16] = mm[i % 16] | mm3;
            if (i == 23) check("xor3_done_early", 32'(done3), 32'd0);
            if (i == 12) check("xor3_vec_mid", 32'(vec3), 32'd4);
        end
        check("xor3_done", 32'(done3), 32'd1);
        check("xor3_pass", 32'(pass3), 32'd1);
        check("xor3_err",  32'(err3),  32'd0);
        check("xor3_mm",   32'(mm),    32'd0);
        check("xor3_vec",  32'(vec3),  32'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gerador_vetores_porta.md
# gerador_vetores_porta

Sequential stimulus generator and self-checker for the basic logic-gate blocks (AND, OR, XOR, NAND). It sits directly upstream of the gate under test. It drives every input combination onto the gate in ascending binary order, waits a settle interval, samples the gate output, and compares it with the expected function. It reports an error count and a pass/fail verdict, so the exhaustive truth-table sweep of a gate can run as synthesizable hardware instead of a hand-written sequence of `$display` steps.

## Interface
Parameters:
- `N_IN`, default 2: number of gate inputs, legal range 1..8.
- `SETTLE`, default 2: number of cycles each vector is held before the check cycle, minimum 1.
- `FUNC`, default 0: expected function. 0 = AND reduction, 1 = OR, 2 = XOR, 3 = NAND. Any other value is treated as AND.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: sweep request. Sampled only when not busy.
- `dut_y`, input, 1: output of the gate under test.
- `vec`, output, N_IN: current input vector, connected to the gate inputs (bit 0 = input `a`, bit 1 = input `b`, and so on).
- `busy`, output, 1: sweep in progress.
- `done`, output, 1: sweep finished. Sticky.
- `pass`, output, 1: high with `done` when `err_count` is 0.
- `err_count`, output, N_IN+1: number of mismatching vectors.
- `mismatch`, output, 1: one-cycle pulse for each failing vector.

## Operation
- All outputs are registered.
- States:
  - IDLE
  - SETTLE: counter runs from SETTLE-1 down to 0.
  - CHECK
- Reset (`rst`=1 at an edge):
  - State goes to IDLE.
  - `vec`, `busy`, `done`, `pass`, `err_count`, `mismatch` all become 0.
  - Reset has priority over every other event, including mid-sweep.
- IDLE with `start`=1: on that edge, move to SETTLE with `vec`=0, `busy`=1, `done`=0, `pass`=0, `err_count`=0 and the counter loaded with SETTLE-1.
- SETTLE: decrement the counter each cycle. When the counter is 0, move to CHECK on the next edge.
- CHECK: on the edge that ends the cycle, compare `dut_y` with expected(FUNC, `vec`).
  - Mismatch: increment `err_count` and set `mismatch`=1 for exactly the following cycle.
  - `vec` ≠ all-ones: increment `vec`, reload the counter, return to SETTLE.
  - `vec` = all-ones: go to IDLE with `busy`=0 and `done`=1. On that same edge, `pass` = (final `err_count` == 0), counting the last vector's result.
- After the sweep ends, `vec` holds its last value (all-ones) until the next start or reset.
- `start` while `busy`=1 is ignored, with no restart and no queuing.
- `start` while `done`=1 clears `done` and `pass` on the acceptance edge and begins a new sweep.
- `err_count` width N_IN+1 holds the maximum value 2^N_IN, so no saturation is needed.

## Timing
- Each vector is held on `vec` for SETTLE+1 cycles: SETTLE cycles of settling plus 1 check cycle.
- `dut_y` is sampled only at the end of the CHECK cycle. The gate path must settle within SETTLE+1 cycles.
- Latency from the start-acceptance edge to the `done`-rising edge is 2^N_IN × (SETTLE+1) cycles.
- `mismatch` is high in the cycle immediately after the failing CHECK cycle. The `err_count` increment is visible in that same cycle.
- `done` and `pass` stay stable until the next start is accepted or reset is asserted.

## Configuration
- Macro `VERIF_STOP_ON_FAIL_EN`.
- Defined: the first mismatch ends the sweep on that CHECK edge.
  - State goes to IDLE with `busy`=0, `done`=1, `pass`=0, `err_count`=1.
  - `vec` holds the failing vector for diagnosis.
- Undefined: the sweep always covers all 2^N_IN vectors and counts every failure.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles mid-sweep (at `vec`=2'b10). Required: all outputs are 0 on the next edge and the block is in IDLE; a new `start` then begins at `vec`=00.
- **Correct gate:** N_IN=2, SETTLE=2, FUNC=0 with a correct AND model; pulse `start`. Required:
  - `vec` sequence 00, 01, 10, 11, each held 3 cycles.
  - `done`=1 after 12 cycles, `pass`=1, `err_count`=0, no `mismatch` pulses.
- **Wrong gate:** same setup, with an OR model in place of the AND. Required: `mismatch` pulses after vectors 01 and 10, final `err_count`=2, `pass`=0.
- **Stuck-at-1 output:** `dut_y` tied to 1. Required:
  - Without the macro: `err_count`=3 after 12 cycles.
  - With `VERIF_STOP_ON_FAIL_EN`: `done` after 3 cycles, `vec`=00, `err_count`=1.
- **Start during sweep:** `start` held high throughout a sweep. Required: the sweep is not restarted; after `done`, the next edge with `start`=1 clears `done` and `pass` and `vec` restarts at 00.
- **XOR, 3 inputs:** N_IN=3, FUNC=2 with a correct 3-input XOR model. Required: 8 vectors, `done` after 24 cycles, `pass`=1, `err_count`=0.
